// File: rtl/pic_alu_pkg.sv
// Purpose: shared definitions for the ALU execution stage: operation codes,
//          skip-condition codes, status bit positions, skip FSM states and
//          small decode helpers used by alu_exec.
package pic_alu_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned SKIPOP_W = 2;
    localparam int unsigned STAT_W   = 3;

    // Operation select codes
    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_COM  = 4'd5;
    localparam logic [OP_W-1:0] ALU_INC  = 4'd6;
    localparam logic [OP_W-1:0] ALU_DEC  = 4'd7;
    localparam logic [OP_W-1:0] ALU_RLF  = 4'd8;
    localparam logic [OP_W-1:0] ALU_RRF  = 4'd9;
    localparam logic [OP_W-1:0] ALU_SWAP = 4'd10;
    localparam logic [OP_W-1:0] ALU_PSA  = 4'd11;
    localparam logic [OP_W-1:0] ALU_PSB  = 4'd12;
    localparam logic [OP_W-1:0] ALU_BIC  = 4'd13;

    // Skip condition codes (2'b11 behaves as none)
    localparam logic [SKIPOP_W-1:0] SKIP_NONE = 2'b00;
    localparam logic [SKIPOP_W-1:0] SKIP_ZERO = 2'b01;
    localparam logic [SKIPOP_W-1:0] SKIP_NZ   = 2'b10;

    // Bit positions inside status = {Z, DC, C}
    localparam int unsigned STAT_C  = 0;
    localparam int unsigned STAT_DC = 1;
    localparam int unsigned STAT_Z  = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SKIP = 1'b1
    } skip_state_e;

    // Ops that are allowed to change C when cwe is set
    function automatic logic op_sets_c(input logic [OP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_RLF) || (op == ALU_RRF);
    endfunction

    // Ops that are allowed to change DC when cwe is set
    function automatic logic op_sets_dc(input logic [OP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

    // Codes 14/15 pass A through and never touch flags
    function automatic logic op_is_reserved(input logic [OP_W-1:0] op);
        return op > ALU_BIC;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: purely combinational ALU datapath.
// Ports:
//   a, b        operands
//   op          operation select (pic_alu_pkg ALU_* codes)
//   c_in        current C flag, rotated in by RLF/RRF
//   result      ALU result (mod 2^WIDTH)
//   carry       carry/no-borrow/rotated-out bit for ADD/SUB/RLF/RRF, else 0
//   half_carry  low-half carry (ADD) or low-half no-borrow (SUB), else 0
module alu_core
    import pic_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             half_carry
);

    localparam int unsigned HALF = WIDTH / 2;

    logic [WIDTH:0] sum_full;
    logic [HALF:0]  sum_half;

    // Widened adders expose carry out of the full word and of the low half
    assign sum_full = {1'b0, a} + {1'b0, b};
    assign sum_half = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]};

    always_comb begin
        result     = a;
        carry      = 1'b0;
        half_carry = 1'b0;
        case (op)
            ALU_ADD: begin
                result     = sum_full[WIDTH-1:0];
                carry      = sum_full[WIDTH];
                half_carry = sum_half[HALF];
            end
            ALU_SUB: begin
                result     = a - b;
                carry      = (a >= b);
                half_carry = (a[HALF-1:0] >= b[HALF-1:0]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_COM:  result = ~a;
            ALU_INC:  result = a + WIDTH'(1);
            ALU_DEC:  result = a - WIDTH'(1);
            ALU_RLF: begin
                result = {a[WIDTH-2:0], c_in};
                carry  = a[WIDTH-1];
            end
            ALU_RRF: begin
                result = {c_in, a[WIDTH-1:1]};
                carry  = a[0];
            end
            ALU_SWAP: result = {a[HALF-1:0], a[WIDTH-1:HALF]};
            ALU_PSA:  result = a;
            ALU_PSB:  result = b;
            ALU_BIC:  result = a & ~b;
            default:  result = a;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Purpose: ALU execution stage. Produces aluout combinationally from the
//          registered operands, owns the W register, the {Z,DC,C} status
//          flags and the skip-next-instruction state machine.
// Build option: define ALU_DC_EN to implement the DC (half-carry) flag;
//          without it status[1] is constant 0.
// Ports:
//   clk2     clock, rising edge
//   reset    synchronous active-high reset
//   valid    instruction valid; gates all state updates
//   alua/alub operands
//   aluop    operation select
//   wwe/fwe  W write / file write requests
//   zwe/cwe  Z / C(+DC) update enables
//   stat_wr  direct status load from aluout[2:0]
//   skip_op  00 none, 01 skip if result==0, 10 skip if result!=0, 11 none
//   aluout   combinational result
//   fwe_out  qualified file write enable
//   w        W register
//   status   {Z,DC,C}
//   skip     high while the next valid instruction will be squashed
module alu_exec
    import pic_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk2,
    input  logic                reset,
    input  logic                valid,
    input  logic [WIDTH-1:0]    alua,
    input  logic [WIDTH-1:0]    alub,
    input  logic [OP_W-1:0]     aluop,
    input  logic                wwe,
    input  logic                fwe,
    input  logic                zwe,
    input  logic                cwe,
    input  logic                stat_wr,
    input  logic [SKIPOP_W-1:0] skip_op,
    output logic [WIDTH-1:0]    aluout,
    output logic                fwe_out,
    output logic [WIDTH-1:0]    w,
    output logic [STAT_W-1:0]   status,
    output logic                skip
);

    logic [WIDTH-1:0]  w_q, w_d;
    logic [STAT_W-1:0] status_q, status_d;
    skip_state_e       state_q, state_d;

    logic carry;
    logic half_carry;
    logic commit;
    logic skip_hit;
    logic res_zero;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a          (alua),
        .b          (alub),
        .op         (aluop),
        .c_in       (status_q[STAT_C]),
        .result     (aluout),
        .carry      (carry),
        .half_carry (half_carry)
    );

    // An instruction takes effect only if valid and not being squashed
    assign commit   = valid && (state_q == ST_RUN);
    assign res_zero = (aluout == '0);
    assign skip_hit = ((skip_op == SKIP_ZERO) &&  res_zero) ||
                      ((skip_op == SKIP_NZ)   && !res_zero);

`ifndef ALU_DC_EN
    logic unused_half_carry;
    assign unused_half_carry = half_carry;
`endif

    // W next-state
    always_comb begin
        w_d = w_q;
        if (commit && wwe) begin
            w_d = aluout;
        end
    end

    // Status next-state: direct load first, ALU flags then overwrite their bits
    always_comb begin
        status_d = status_q;
        if (commit) begin
            if (stat_wr) begin
                status_d = aluout[STAT_W-1:0];
            end
            if (zwe && !op_is_reserved(aluop)) begin
                status_d[STAT_Z] = res_zero;
            end
            if (cwe && op_sets_c(aluop)) begin
                status_d[STAT_C] = carry;
            end
`ifdef ALU_DC_EN
            if (cwe && op_sets_dc(aluop)) begin
                status_d[STAT_DC] = half_carry;
            end
`endif
        end
`ifndef ALU_DC_EN
        status_d[STAT_DC] = 1'b0;
`endif
    end

    // Datapath registers
    always_ff @(posedge clk2) begin
        if (reset) begin
            w_q      <= '0;
            status_q <= '0;
        end else begin
            w_q      <= w_d;
            status_q <= status_d;
        end
    end

    // Skip FSM: state register
    always_ff @(posedge clk2) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Skip FSM: next state; the squashed instruction's skip_op is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (valid && skip_hit) state_d = ST_SKIP;
            ST_SKIP: if (valid)             state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Skip FSM: outputs
    always_comb begin
        skip    = (state_q == ST_SKIP);
        fwe_out = fwe && valid && (state_q == ST_RUN);
    end

    assign w      = w_q;
    assign status = status_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboarded directed test of alu_exec. Expected status values are written
// with DC included; when DC is not built the bench clears bit 1.
module tb_alu_exec;
    import pic_alu_pkg::*;

    localparam int unsigned W = 8;

    logic         clk2 = 1'b0;
    logic         reset;
    logic         valid;
    logic [W-1:0] alua, alub;
    logic [3:0]   aluop;
    logic         wwe, fwe, zwe, cwe, stat_wr;
    logic [1:0]   skip_op;
    logic [W-1:0] aluout;
    logic         fwe_out;
    logic [W-1:0] w;
    logic [2:0]   status;
    logic         skip;

    alu_exec #(.WIDTH(W)) dut (
        .clk2    (clk2),
        .reset   (reset),
        .valid   (valid),
        .alua    (alua),
        .alub    (alub),
        .aluop   (aluop),
        .wwe     (wwe),
        .fwe     (fwe),
        .zwe     (zwe),
        .cwe     (cwe),
        .stat_wr (stat_wr),
        .skip_op (skip_op),
        .aluout  (aluout),
        .fwe_out (fwe_out),
        .w       (w),
        .status  (status),
        .skip    (skip)
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic         fwe;
        logic [W-1:0] w;
        logic [2:0]   st;
        logic         sk;
    } exp_t;

    exp_t q[$];
    logic issued;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [2:0] mask_st(input logic [2:0] s);
`ifdef ALU_DC_EN
        return s;
`else
        return s & 3'b101;
`endif
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus and push its expected response
    task automatic issue(input string name, input logic v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ww, input logic fw, input logic zw, input logic cw,
                         input logic sw, input logic [1:0] sop,
                         input logic [W-1:0] e_out, input logic e_fwe,
                         input logic [W-1:0] e_w, input logic [2:0] e_st, input logic e_sk);
        exp_t e;
        @(posedge clk2); #1;
        valid = v; aluop = op; alua = a; alub = b;
        wwe = ww; fwe = fw; zwe = zw; cwe = cw; stat_wr = sw; skip_op = sop;
        e.name = name; e.out = e_out; e.fwe = e_fwe; e.w = e_w;
        e.st = mask_st(e_st); e.sk = e_sk;
        q.push_back(e);
        issued = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk2); #1;
        issued = 1'b0;
        valid = 1'b0; wwe = 1'b0; fwe = 1'b0; zwe = 1'b0; cwe = 1'b0;
        stat_wr = 1'b0; skip_op = 2'b00;
    endtask

    // Monitor: combinational outputs mid-cycle, registered state after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk2);
            if (issued && q.size() > 0) begin
                e = q.pop_front();
                cmp({e.name, ".aluout"},  32'(aluout),  32'(e.out));
                cmp({e.name, ".fwe_out"}, 32'(fwe_out), 32'(e.fwe));
                @(posedge clk2); #1;
                cmp({e.name, ".w"},       32'(w),       32'(e.w));
                cmp({e.name, ".status"},  32'(status),  32'(e.st));
                cmp({e.name, ".skip"},    32'(skip),    32'(e.sk));
            end
        end
    end

    initial begin
        int guard;
        issued = 1'b0; reset = 1'b1; valid = 1'b0;
        alua = '0; alub = '0; aluop = '0;
        wwe = 0; fwe = 0; zwe = 0; cwe = 0; stat_wr = 0; skip_op = 2'b00;
        repeat (2) @(posedge clk2);
        #1 reset = 1'b0;
        cmp("reset.w", 32'(w), 32'h0);
        cmp("reset.status", 32'(status), 32'h0);
        cmp("reset.skip", 32'(skip), 32'h0);

        //     name      v op        a      b      ww fw zw cw sw sop   out    fwe w      st      sk
        issue("add_z",  1, ALU_ADD,  8'hF8, 8'h08, 0, 0, 1, 1, 0, 2'b00, 8'h00, 0, 8'h00, 3'b111, 0);
        issue("sub_lt", 1, ALU_SUB,  8'h03, 8'h05, 0, 0, 0, 1, 0, 2'b00, 8'hFE, 0, 8'h00, 3'b100, 0);
        issue("sub_eq", 1, ALU_SUB,  8'h05, 8'h05, 0, 0, 1, 1, 0, 2'b00, 8'h00, 0, 8'h00, 3'b111, 0);
        issue("rlf_c1", 1, ALU_RLF,  8'h80, 8'h00, 1, 0, 0, 1, 0, 2'b00, 8'h01, 0, 8'h01, 3'b111, 0);
        issue("clr_c",  1, ALU_SUB,  8'h03, 8'h05, 0, 0, 0, 1, 0, 2'b00, 8'hFE, 0, 8'h01, 3'b100, 0);
        issue("rrf_c0", 1, ALU_RRF,  8'h01, 8'h00, 0, 0, 0, 1, 0, 2'b00, 8'h00, 0, 8'h01, 3'b101, 0);
        issue("dec_sk", 1, ALU_DEC,  8'h01, 8'h00, 0, 0, 0, 0, 0, 2'b01, 8'h00, 0, 8'h01, 3'b101, 1);
        issue("bubble", 0, ALU_PSA,  8'h00, 8'h00, 1, 1, 0, 0, 0, 2'b01, 8'h00, 0, 8'h01, 3'b101, 1);
        issue("squash", 1, ALU_ADD,  8'h10, 8'h20, 1, 1, 1, 1, 0, 2'b01, 8'h30, 0, 8'h01, 3'b101, 0);
        issue("add_w",  1, ALU_ADD,  8'h10, 8'h20, 1, 1, 0, 0, 0, 2'b11, 8'h30, 1, 8'h30, 3'b101, 0);
        issue("prec",   1, ALU_PSB,  8'h00, 8'h07, 0, 0, 1, 0, 1, 2'b00, 8'h07, 0, 8'h30, 3'b011, 0);
        issue("resvd",  1, 4'd14,    8'h00, 8'hFF, 0, 0, 1, 1, 0, 2'b00, 8'h00, 0, 8'h30, 3'b011, 0);
        issue("swap",   1, ALU_SWAP, 8'hA5, 8'h00, 1, 0, 0, 0, 0, 2'b00, 8'h5A, 0, 8'h5A, 3'b011, 0);
        issue("xor_nz", 1, ALU_XOR,  8'hFF, 8'h0F, 0, 0, 0, 0, 0, 2'b10, 8'hF0, 0, 8'h5A, 3'b011, 1);
        idle();

        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(posedge clk2);
            guard++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end

        // Reset while in SKIP
        @(posedge clk2); #1;
        cmp("pre_rst.skip", 32'(skip), 32'h1);
        reset = 1'b1;
        @(posedge clk2); #1;
        reset = 1'b0;
        cmp("rst_skip.skip", 32'(skip), 32'h0);
        cmp("rst_skip.w", 32'(w), 32'h0);
        cmp("rst_skip.status", 32'(status), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
